instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches one 32-bit instruction at a time from instruction memory, holds it
// in the instruction register (IR) until the execute stage consumes it, then
// advances the PC either sequentially (+4) or to a taken B-type branch target.
// A memory that does not answer within TIMEOUT wait cycles parks the unit in a
// terminal error state with a sticky fetch_err flag; only rst_n recovers.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request (high for every S_FETCH cycle)
//   imem_addr    byte address of the requested instruction (always PC)
//   imem_rdata   instruction word from memory, valid while imem_ready=1
//   imem_ready   memory delivers imem_rdata this cycle
//   ex_done      execute stage has consumed the held instruction
//   Branch       branch flag for the held instruction
//   Zero         ALU zero flag for the held instruction
//   BrOffset     signed 13-bit B-type byte offset
//   instr_valid  Instr and decoded fields are valid
//   Instr        instruction register
//   OP/Funct3/Funct7  opcode / funct3 / funct7 slices of Instr
//   PC           address of the instruction held in Instr
//   fetch_err    sticky memory-timeout flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  input  logic              ex_done,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [12:0]       BrOffset,
  output logic              instr_valid,
  output logic [31:0]       Instr,
  output logic [6:0]        OP,
  output logic [2:0]        Funct3,
  output logic [6:0]        Funct7,
  output logic [ADDR_W-1:0] PC,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt, wait_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt, pc_seq, br_sum;
  logic [31:0]       ir_q;
  logic              err_q;
  logic              ir_load, pc_load, err_set;

  // Next PC. The offset is sign-extended (or truncated) to ADDR_W by the size
  // cast, so both additions wrap silently modulo 2^ADDR_W. Branch targets are
  // forced word-aligned.
  always_comb begin
    pc_seq = pc_q + ADDR_W'(4);
    br_sum = pc_q + ADDR_W'($signed(BrOffset));
    pc_nxt = (Branch && Zero) ? (br_sum & ~ADDR_W'(3)) : pc_seq;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    err_set     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        // A late answer on the timeout cycle still wins over the error.
        if (imem_ready) begin
          ir_load   = 1'b1;
          wait_nxt  = 4'd0;
          state_nxt = S_HOLD;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          err_set   = 1'b1;
          state_nxt = S_ERR;
        end else begin
          wait_nxt  = wait_cnt + 4'd1;
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (ex_done) begin
          pc_load   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_ERR: ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: IR is a single register, not a memory, so it is cleared on reset
  // along with the rest of the datapath to give well-defined outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (ir_load) ir_q  <= imem_rdata;
      if (pc_load) pc_q  <= pc_nxt;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign Instr     = ir_q;
  assign OP        = ir_q[6:0];
  assign Funct3    = ir_q[14:12];
  assign Funct7    = ir_q[31:25];
  assign fetch_err = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed plus randomized bench for instr_fetch_unit. The reference model
// tracks only the architectural PC and the instruction last delivered; next-PC
// values are computed with plain integer arithmetic modulo 256.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int          ADDR_W   = 8;
  localparam int          TIMEOUT  = 15;
  localparam logic [7:0]  RESET_PC = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        ex_done = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic [12:0] BrOffset = '0;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [6:0]  OP;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [7:0]  PC;
  logic        fetch_err;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .ex_done     (ex_done),
    .Branch      (Branch),
    .Zero        (Zero),
    .BrOffset    (BrOffset),
    .instr_valid (instr_valid),
    .Instr       (Instr),
    .OP          (OP),
    .Funct3      (Funct3),
    .Funct7      (Funct7),
    .PC          (PC),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  m_pc;
  logic [31:0] m_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge: inputs are driven and outputs
  // sampled there, well away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule in plain integer arithmetic.
  function automatic logic [7:0] next_pc(input logic [7:0] pc, input bit br,
                                         input bit z, input int off);
    int t;
    if (br && z) begin
      t = (int'(pc) + off) & 255;
      t = (t / 4) * 4;
    end else begin
      t = (int'(pc) + 4) & 255;
    end
    return t[7:0];
  endfunction

  // Assert reset between edges, check the asynchronous effect before the next
  // edge, release, then expect exactly one idle cycle before the fetch.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, "_req"},   imem_req,    1'b0);
    check({tag, "_valid"}, instr_valid, 1'b0);
    check({tag, "_pc"},    PC,          RESET_PC);
    check({tag, "_ir"},    Instr,       32'h0);
    check({tag, "_err"},   fetch_err,   1'b0);
    step();
    rst_n   = 1'b1;
    ex_done = 1'b0;
    Branch  = 1'b0;
    Zero    = 1'b0;
    check({tag, "_idle_req"}, imem_req, 1'b0);
    step();
    check({tag, "_fetch_req"},  imem_req,  1'b1);
    check({tag, "_fetch_addr"}, imem_addr, RESET_PC);
    m_pc = RESET_PC;
  endtask

  // Serve one fetch with 'waits' not-ready cycles, then deliver 'word'.
  // Execute-side inputs are toggled randomly meanwhile; they must be ignored.
  task automatic fetch_word(input int waits, input logic [31:0] word);
    int guard = 0;
    while (!imem_req && guard < 4) begin
      step();
      guard++;
    end
    check("fetch_req",  imem_req,  1'b1);
    check("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      ex_done    = 1'($urandom);
      Branch     = 1'($urandom);
      Zero       = 1'($urandom);
      BrOffset   = 13'($urandom);
      step();
      check("wait_valid", instr_valid, 1'b0);
      check("wait_req",   imem_req,    1'b1);
      check("wait_addr",  imem_addr,   m_pc);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    ex_done    = 1'($urandom);
    step();
    m_instr    = word;
    imem_ready = 1'b0;
    ex_done    = 1'b0;
    check("hold_valid",  instr_valid, 1'b1);
    check("hold_req",    imem_req,    1'b0);
    check("hold_ir",     Instr,       word);
    check("hold_op",     OP,          word[6:0]);
    check("hold_funct3", Funct3,      word[14:12]);
    check("hold_funct7", Funct7,      word[31:25]);
    check("hold_pc",     PC,          m_pc);
    check("hold_err",    fetch_err,   1'b0);
  endtask

  // Keep the instruction for 'hold_cycles', then consume it with the given
  // branch inputs and check the next fetch address.
  task automatic retire(input int hold_cycles, input bit br, input bit z, input int off);
    for (int i = 0; i < hold_cycles; i++) begin
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      ex_done    = 1'b0;
      Branch     = 1'($urandom);
      Zero       = 1'($urandom);
      step();
      check("stall_valid", instr_valid, 1'b1);
      check("stall_ir",    Instr,       m_instr);
      check("stall_pc",    PC,          m_pc);
    end
    imem_ready = 1'b0;
    ex_done    = 1'b1;
    Branch     = br;
    Zero       = z;
    BrOffset   = off[12:0];
    step();
    ex_done = 1'b0;
    Branch  = 1'b0;
    Zero    = 1'b0;
    m_pc    = next_pc(m_pc, br, z, off);
    check("next_valid", instr_valid, 1'b0);
    check("next_req",   imem_req,    1'b1);
    check("next_addr",  imem_addr,   m_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waits, hold, off, br, z;
    #1;
    do_reset("por");

    // addi x0,x0,0 from address 0, zero-wait memory
    fetch_word(0, 32'h0000_0013);
    check("addi_op",     OP,     7'b0010011);
    check("addi_funct3", Funct3, 3'b000);
    retire(0, 1'b0, 1'b0, 0);                       // -> 0x04

    // three wait cycles: valid rises four cycles after the first fetch cycle
    fetch_word(3, $urandom);
    retire(1, 1'b0, 1'b1, 0);                       // Zero alone: -> 0x08
    fetch_word(1, $urandom);
    retire(0, 1'b0, 1'b0, 0);                       // -> 0x0C
    fetch_word(0, $urandom);
    retire(2, 1'b0, 1'b0, 0);                       // -> 0x10

    // branches from 0x10
    fetch_word(2, $urandom);
    check("br_base_pc", PC, 8'h10);
    retire(0, 1'b1, 1'b1, -8);                      // taken -> 0x08
    check("br_taken_addr", imem_addr, 8'h08);
    fetch_word(0, $urandom);
    retire(0, 1'b1, 1'b1, 8);                       // -> 0x10
    fetch_word(0, $urandom);
    retire(0, 1'b1, 1'b0, -8);                      // not taken -> 0x14
    check("br_not_taken_addr", imem_addr, 8'h14);
    fetch_word(0, $urandom);
    retire(0, 1'b1, 1'b1, 6);                       // 0x1A aligned -> 0x18

    // wrap in both directions and extreme offset
    fetch_word(0, $urandom);
    retire(0, 1'b1, 1'b1, 228);                     // -> 0xFC
    fetch_word(0, $urandom);
    retire(0, 1'b0, 1'b0, 0);                       // 0xFC + 4 -> 0x00
    check("wrap_up_addr", imem_addr, 8'h00);
    fetch_word(0, $urandom);
    retire(0, 1'b1, 1'b1, -4);                      // 0x00 - 4 -> 0xFC
    check("wrap_down_addr", imem_addr, 8'hFC);

    // ready on the timeout cycle wins over the error
    fetch_word(TIMEOUT, $urandom);
    retire(0, 1'b1, 1'b1, -4096);                   // -> 0xFC

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      waits = int'($urandom_range(0, 6));
      hold  = int'($urandom_range(0, 3));
      br    = int'($urandom_range(0, 1));
      z     = int'($urandom_range(0, 1));
      off   = int'($urandom_range(0, 8191)) - 4096;
      fetch_word(waits, $urandom);
      retire(hold, br[0], z[0], off);
    end

    // reset while holding the instruction at 0x20
    fetch_word(0, $urandom);
    retire(0, 1'b1, 1'b1, 32 - int'(m_pc));
    fetch_word(1, $urandom);
    check("rst_hold_pc", PC, 8'h20);
    ex_done = 1'b1;
    Branch  = 1'b1;
    Zero    = 1'b1;
    do_reset("hold_rst");
    fetch_word(0, $urandom);
    retire(0, 1'b0, 1'b0, 0);                       // -> 0x04

    // memory never answers: 16 low cycles give a terminal error
    imem_ready = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      check("to_pending_err", fetch_err, 1'b0);
      check("to_pending_req", imem_req,  1'b1);
    end
    step();
    check("to_err",   fetch_err,   1'b1);
    check("to_req",   imem_req,    1'b0);
    check("to_valid", instr_valid, 1'b0);
    for (int k = 0; k < 5; k++) begin
      imem_ready = 1'b1;
      ex_done    = 1'($urandom);
      step();
      check("err_sticky", fetch_err, 1'b1);
      check("err_req",    imem_req,  1'b0);
      check("err_valid",  instr_valid, 1'b0);
    end
    imem_ready = 1'b0;
    do_reset("err_rst");
    fetch_word(0, $urandom);
    retire(0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
